// File: rtl/disp_pkg.sv
// Shared types and constants for the display scheduler and its BCD converter.
// Latency: n/a (declarations and one combinational helper).
// Backpressure: n/a.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CONV = 2'd2,
        SHOW = 2'd3
    } state_t;

    localparam int BIN_W      = 14;
    localparam int BCD_W      = 16;
    localparam int CONV_STEPS = 14;

    localparam logic [BCD_W-1:0] BCD_MAX   = 16'h9999;
    localparam logic [BIN_W-1:0] DEC_LIMIT = 14'd9999;

    // One double-dabble step on {bcd, bin}: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [BCD_W+BIN_W-1:0] dd_step(input logic [BCD_W+BIN_W-1:0] s);
        logic [BCD_W+BIN_W-1:0] a;
        a = s;
        for (int k = 0; k < BCD_W / 4; k++) begin
            if (a[BIN_W+4*k +: 4] >= 4'd5) begin
                a[BIN_W+4*k +: 4] = a[BIN_W+4*k +: 4] + 4'd3;
            end
        end
        return {a[BCD_W+BIN_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/disp_sched_if.sv
// Requester-side bundle of the display scheduler plus its display-driver outputs.
// Latency: n/a (wiring only).
// Backpressure: req is a level held until done; there is no other stall path.
interface disp_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [16*NREQ-1:0] val;
    logic [NREQ-1:0]    dec;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [15:0]        disp_x;
    logic [3:0]         disp_aen;
    logic               busy;

    modport master (
        output req, val, dec,
        input  gnt, done, disp_x, disp_aen, busy
    );

    modport slave (
        input  req, val, dec,
        output gnt, done, disp_x, disp_aen, busy
    );
endinterface

// File: rtl/dd_conv.sv
// Sequential 14-bit binary to 4-digit BCD converter (double-dabble).
// Latency: rdy pulses 14 cycles after start; the first step is folded into the start cycle.
// Backpressure: none; a new start restarts the conversion.
module dd_conv
    import disp_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             rdy
);

    logic [BCD_W+BIN_W-1:0] sh_q;
    logic [3:0]             step_q;
    logic                   run_q;

    // Shift register and step counter; start applies step 1, each following cycle one more.
    always_ff @(posedge clk) begin
        if (clr) begin
            sh_q   <= '0;
            step_q <= 4'd0;
            run_q  <= 1'b0;
            rdy    <= 1'b0;
        end else begin
            rdy <= 1'b0;
            if (start) begin
                sh_q   <= dd_step({{BCD_W{1'b0}}, bin});
                step_q <= 4'd1;
                run_q  <= 1'b1;
            end else if (run_q) begin
                sh_q   <= dd_step(sh_q);
                step_q <= step_q + 4'd1;
                if (step_q == 4'(CONV_STEPS - 1)) begin
                    run_q <= 1'b0;
                    rdy   <= 1'b1;
                end
            end
        end
    end

    assign bcd = sh_q[BCD_W+BIN_W-1:BIN_W];

endmodule

// File: rtl/disp_sched.sv
// Round-robin scheduler sharing one 4-digit 7-seg display among NREQ requesters.
// Latency: gnt 1 cycle after req; display 2 (hex) / 16 (decimal) cycles; done HOLD_CYC later.
// Backpressure: requesters hold req until done; a grant always runs to completion.
module disp_sched
    import disp_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int HOLD_CYC = 50_000_000
) (
    input  logic         clk,
    input  logic         clr,
    disp_sched_if.slave  bus
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(HOLD_CYC + 1);

    state_t            state_q;
    logic [IW-1:0]     last_q;
    logic [CW-1:0]     dwell_q;
    logic              sat_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic [15:0]       disp_q;

    logic              found;
    logic [IW-1:0]     pick;
    logic [15:0]       wval;
    logic              wdec;
    logic              conv_start;
    logic [BCD_W-1:0]  conv_bcd;
    logic              conv_rdy;

    // last_q holds the current winner from the grant onwards, so it also selects its inputs.
    assign wval = bus.val[16*last_q +: 16];
    assign wdec = bus.dec[last_q];

    // Round-robin search starting just after the last winner.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = last_q;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    assign conv_start = (state_q == LOAD) && wdec;

    dd_conv u_conv (
        .clk   (clk),
        .clr   (clr),
        .start (conv_start),
        .bin   (wval[BIN_W-1:0]),
        .bcd   (conv_bcd),
        .rdy   (conv_rdy)
    );

    // Main sequencer: arbitrate, load, convert, dwell, then acknowledge.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            last_q  <= IW'(NREQ - 1);
            dwell_q <= '0;
            sat_q   <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            disp_q  <= 16'h0000;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        gnt_q   <= NREQ'(1) << pick;
                        last_q  <= pick;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    sat_q   <= wval[BIN_W-1:0] > DEC_LIMIT;
                    dwell_q <= '0;
                    if (wdec) begin
                        state_q <= CONV;
                    end else begin
                        disp_q  <= wval;
                        state_q <= SHOW;
                    end
                end
                CONV: begin
                    // The display only ever takes the finished (or saturated) result.
                    if (conv_rdy) begin
                        disp_q  <= sat_q ? BCD_MAX : conv_bcd;
                        dwell_q <= '0;
                        state_q <= SHOW;
                    end
                end
                SHOW: begin
                    if (dwell_q == CW'(HOLD_CYC - 1)) begin
                        dwell_q <= '0;
                        gnt_q   <= '0;
                        done_q  <= NREQ'(1) << last_q;
                        state_q <= IDLE;
                    end else begin
                        dwell_q <= dwell_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.disp_x   = disp_q;
    assign bus.disp_aen = {|disp_q[15:12], |disp_q[15:8], |disp_q[15:4], 1'b1};

endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched with a reference model of arbitration and display.
// Latency: n/a.
// Backpressure: n/a.
module tb_disp_sched;

    localparam int NREQ = 4;
    localparam int HOLD = 4;

    logic clk;
    logic clr;

    disp_sched_if #(.NREQ(NREQ)) bus ();

    disp_sched #(.NREQ(NREQ), .HOLD_CYC(HOLD)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          last  = NREQ - 1;
    logic [15:0] shown = 16'h0000;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Expected display word: hex passes through, decimal is the saturated base-10 digits.
    function automatic logic [15:0] exp_disp(input logic [15:0] v, input logic d);
        int n;
        if (!d) return v;
        n = int'(v[13:0]);
        if (n > 9999) n = 9999;
        return 16'((n / 1000) * 4096 + ((n / 100) % 10) * 256 + ((n / 10) % 10) * 16 + n % 10);
    endfunction

    function automatic logic [3:0] exp_aen(input logic [15:0] x);
        if (x >= 16'h1000) return 4'b1111;
        if (x >= 16'h0100) return 4'b0111;
        if (x >= 16'h0010) return 4'b0011;
        return 4'b0001;
    endfunction

    // Runs one grant from the current negedge (req already driven) to its done cycle.
    task automatic do_txn(input bit scramble);
        logic [3:0]  mask;
        logic [15:0] v;
        logic        d;
        logic [15:0] ex;
        logic [3:0]  oh;
        int          w;
        int          lat;
        mask = bus.req;
        w = -1;
        for (int i = 1; i <= NREQ; i++) begin
            int idx;
            idx = (last + i) % NREQ;
            if (w < 0 && mask[idx]) w = idx;
        end
        if (w < 0) begin
            $display("FAIL txn_setup: no requester asserted");
            $fatal(1, "bench setup error");
        end
        v   = bus.val[16*w +: 16];
        d   = bus.dec[w];
        ex  = exp_disp(v, d);
        oh  = 4'(1 << w);
        lat = d ? 16 : 2;
        for (int k = 1; k <= lat + HOLD; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("gnt", 16'(bus.gnt), 16'(oh));
                chk("busy", 16'(bus.busy), 16'd1);
            end
            if (k == 2 && scramble) begin
                bus.req[w]          = 1'b0;
                bus.val[16*w +: 16] = ~v;
                bus.dec[w]          = ~d;
            end
            if (k == lat - 1) chk("disp_hold", bus.disp_x, shown);
            if (k == lat) begin
                chk("disp_x", bus.disp_x, ex);
                chk("disp_aen", 16'(bus.disp_aen), 16'(exp_aen(ex)));
            end
            if (k < lat + HOLD) begin
                chk("done_early", 16'(bus.done), 16'd0);
            end else begin
                chk("done", 16'(bus.done), 16'(oh));
                chk("gnt_clear", 16'(bus.gnt), 16'd0);
                chk("busy_clear", 16'(bus.busy), 16'd0);
            end
        end
        last  = w;
        shown = ex;
    endtask

    initial begin
        clr     = 1'b1;
        bus.req = '0;
        bus.val = '0;
        bus.dec = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 16'(bus.gnt), 16'd0);
        chk("rst_done", 16'(bus.done), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_disp", bus.disp_x, 16'h0000);
        chk("rst_aen", 16'(bus.disp_aen), 16'h0001);
        clr = 1'b0;

        // Hex on requester 0.
        bus.req = 4'b0001;
        bus.val[15:0] = 16'h00A5;
        do_txn(1'b0);

        // Decimal on requester 1: ordinary, max, saturating, zero.
        bus.req = 4'b0010;
        bus.dec = 4'b0010;
        bus.val[31:16] = 16'd1234;
        do_txn(1'b0);
        bus.val[31:16] = 16'd9999;
        do_txn(1'b0);
        bus.val[31:16] = 16'd10000;
        do_txn(1'b0);
        bus.val[31:16] = 16'd0;
        do_txn(1'b0);

        // Reset held two cycles during SHOW.
        bus.req = 4'b0001;
        bus.dec = 4'b0000;
        bus.val[15:0] = 16'h1234;
        repeat (4) @(negedge clk);
        chk("pre_rst_disp", bus.disp_x, 16'h1234);
        clr = 1'b1;
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        chk("mid_rst_gnt", 16'(bus.gnt), 16'd0);
        chk("mid_rst_done", 16'(bus.done), 16'd0);
        chk("mid_rst_busy", 16'(bus.busy), 16'd0);
        chk("mid_rst_disp", bus.disp_x, 16'h0000);
        chk("mid_rst_aen", 16'(bus.disp_aen), 16'h0001);
        last  = NREQ - 1;
        shown = 16'h0000;
        repeat (6) begin
            @(negedge clk);
            chk("mid_rst_no_done", 16'(bus.done), 16'd0);
        end

        // Abort in the middle of a conversion.
        bus.req = 4'b0100;
        bus.dec = 4'b0100;
        bus.val[47:32] = 16'd4321;
        repeat (8) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        bus.req = 4'b0000;
        chk("abort_busy", 16'(bus.busy), 16'd0);
        chk("abort_gnt", 16'(bus.gnt), 16'd0);
        chk("abort_disp", bus.disp_x, 16'h0000);
        repeat (20) begin
            @(negedge clk);
            chk("abort_no_done", 16'(bus.done), 16'd0);
        end
        last = NREQ - 1;
        bus.req = 4'b0100;
        do_txn(1'b0);

        // Round-robin between 0 and 2, then 1 joins.
        bus.dec = 4'b0000;
        bus.val = {16'h0003, 16'h0220, 16'h0011, 16'hF000};
        bus.req = 4'b0101;
        do_txn(1'b0);
        do_txn(1'b0);
        do_txn(1'b0);
        bus.req = 4'b0111;
        do_txn(1'b0);
        bus.req = 4'b0101;
        do_txn(1'b0);

        // Requester 3 drops req and changes its inputs after LOAD.
        bus.req = 4'b1000;
        bus.dec = 4'b1000;
        bus.val[63:48] = 16'd777;
        do_txn(1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("holdover_single_done", 16'(bus.done), 16'd0);
            chk("holdover_idle", 16'(bus.busy), 16'd0);
        end

        // Randomized transactions.
        for (int r = 0; r < 12; r++) begin
            bus.req = 4'($urandom_range(1, 15));
            bus.dec = 4'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                bus.val[16*i +: 16] = 16'($urandom);
            end
            do_txn(1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
